// File: rtl/dec_seq.sv
// Registered N-to-2^N one-hot decoder with a scan sequencer that sweeps the
// one-hot output over an address range, holding each position for a programmable dwell.
module dec_seq #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [N-1:0]       addr,
    input  logic [N-1:0]       scan_last,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic [2**N-1:0]    y,
    output logic               y_valid,
    output logic               busy,
    output logic               done
);

    localparam int unsigned W = 2**N;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N-1:0]       cursor_q, cursor_d;
    logic [N-1:0]       last_q, last_d;
    logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [N-1:0]       cursor_inc;
    logic               accept;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] a);
        logic [W-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

    assign in_ready   = en && (state_q != SCAN);
    assign accept     = in_valid && in_ready;
    assign cursor_inc = cursor_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cursor_d    = cursor_q;
        last_d      = last_q;
        dwell_cfg_d = dwell_cfg_q;
        dwell_cnt_d = dwell_cnt_q;
        unique case (state_q)
            IDLE, DIRECT: begin
                if (!en) begin
                    state_d   = IDLE;
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end else if (accept) begin
                    y_d       = onehot(addr);
                    y_valid_d = 1'b1;
                    if (mode) begin
                        state_d     = SCAN;
                        busy_d      = 1'b1;
                        cursor_d    = addr;
                        last_d      = scan_last;
                        dwell_cfg_d = dwell;
                        dwell_cnt_d = dwell;
                    end else begin
                        state_d = DIRECT;
                    end
                end
            end
            SCAN: begin
                // Any enabled edge re-drives y from the cursor, so the first edge
                // after a pause both restores the output and consumes a dwell tick.
                if (abort) begin
                    state_d   = IDLE;
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (!en) begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end else if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                    y_d         = onehot(cursor_q);
                    y_valid_d   = 1'b1;
                end else if (cursor_q != last_q) begin
                    cursor_d    = cursor_inc;
                    dwell_cnt_d = dwell_cfg_q;
                    y_d         = onehot(cursor_inc);
                    y_valid_d   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    y_d       = '0;
                    y_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                y_d       = '0;
                y_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cursor_q    <= '0;
            last_q      <= '0;
            dwell_cfg_q <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cursor_q    <= cursor_d;
            last_q      <= last_d;
            dwell_cfg_q <= dwell_cfg_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dec_seq.sv
// Bench for dec_seq: directed vector table and corner sequences on an N=3 instance,
// randomized scans on an N=4 instance against a tick-count reference model.
module tb_dec_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       en, in_valid, mode, abort, in_ready, y_valid, busy, done;
    logic [2:0] addr, scan_last;
    logic [3:0] dwell;
    logic [7:0] y;

    logic        en4, in_valid4, mode4, abort4, in_ready4, y_valid4, busy4, done4;
    logic [3:0]  addr4, scan_last4;
    logic [2:0]  dwell4;
    logic [15:0] y4;

    dec_seq #(.N(3), .DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .addr(addr), .scan_last(scan_last), .dwell(dwell), .abort(abort),
        .y(y), .y_valid(y_valid), .busy(busy), .done(done)
    );

    dec_seq #(.N(4), .DWELL_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4), .addr(addr4), .scan_last(scan_last4), .dwell(dwell4), .abort(abort4),
        .y(y4), .y_valid(y_valid4), .busy(busy4), .done(done4)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic       en, iv, md;
        logic [2:0] a, l;
        logic [3:0] d;
        logic       ab;
        logic       rdy;
        logic [7:0] ey;
        logic       yv, bz, dn;
    } vec_t;

    function automatic vec_t mk(logic e, logic iv, logic md, logic [2:0] a, logic [2:0] l,
                                logic [3:0] d, logic ab, logic rdy, logic [7:0] ey,
                                logic yv, logic bz, logic dn);
        vec_t v;
        v.en = e; v.iv = iv; v.md = md; v.a = a; v.l = l; v.d = d; v.ab = ab;
        v.rdy = rdy; v.ey = ey; v.yv = yv; v.bz = bz; v.dn = dn;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic pause_test();
        int         high;
        int         done_cyc;
        logic       pause_ok;
        logic [7:0] resume_y;
        high = 0; done_cyc = -1; pause_ok = 1'b1; resume_y = '0;
        @(negedge clk);
        en = 1; in_valid = 1; mode = 1; addr = 3'd0; scan_last = 3'd3; dwell = 4'd1;
        @(posedge clk); #1;
        in_valid = 0;
        for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
            if (y != 0) high++;
            if (cyc >= 4 && cyc <= 7 && (y != 0 || busy !== 1'b1)) pause_ok = 1'b0;
            if (cyc == 8) resume_y = y;
            if (done) done_cyc = cyc;
            en = !(cyc >= 3 && cyc <= 6);
            @(posedge clk); #1;
        end
        en = 1;
        check("pause.high_cycles", high, 8);
        check("pause.y0_busy1", pause_ok, 1);
        check("pause.resume_y", resume_y, 8'h02);
        check("pause.done_cycle", done_cyc, 13);
        check("pause.done_one_cycle", done, 0);
    endtask

    task automatic abort_test();
        int waited;
        waited = 0;
        @(negedge clk);
        en = 1; in_valid = 1; mode = 1; addr = 3'd0; scan_last = 3'd5; dwell = 4'd0;
        @(posedge clk); #1;
        in_valid = 0;
        while (y != 8'h04 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("abort.reach_cursor2", y, 8'h04);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort.y", y, 0);
        check("abort.flags", {y_valid, busy, done}, 3'b000);
        @(posedge clk); #1;
        check("abort.no_done", {y, done}, 0);
        check("abort.ready", in_ready, 1);
    endtask

    task automatic reset_test();
        @(negedge clk);
        en = 1; in_valid = 1; mode = 1; addr = 3'd0; scan_last = 3'd7; dwell = 4'd3;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("rst_mid.y", y, 0);
        check("rst_mid.flags", {y_valid, busy, done}, 3'b000);
        @(negedge clk);
        rst_n = 1;
        #1 check("rst_rel.ready_en1", in_ready, 1);
        en = 0;
        #1 check("rst_rel.ready_en0", in_ready, 0);
        en = 1;
        @(posedge clk); #1;
        check("rst_rel.idle", {y, y_valid, busy, done}, 0);
    endtask

    // Reference model for the N=4 instance: a scan is a budget of enabled ticks;
    // tick k shows position start + k/(dwell+1), and reaching the budget ends the scan.
    logic        m_active, m_done;
    int          m_k, m_total, m_start, m_dw;
    logic [15:0] m_y;

    task automatic random_test(input int cycles);
        logic       e, iv, md, ab;
        logic [3:0] a, l;
        logic [2:0] d;
        m_active = 0; m_done = 0; m_k = 0; m_total = 0; m_start = 0; m_dw = 0; m_y = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            e  = ($urandom_range(0, 9) != 0);
            iv = ($urandom_range(0, 2) == 0);
            md = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 99) == 0);
            a  = 4'($urandom);
            l  = 4'($urandom);
            d  = 3'($urandom);
            en4 = e; in_valid4 = iv; mode4 = md; abort4 = ab;
            addr4 = a; scan_last4 = l; dwell4 = d;
            #1 check("rnd.ready", in_ready4, e && !m_active);
            @(posedge clk);
            m_done = 0;
            if (m_active) begin
                if (ab) begin
                    m_active = 0; m_y = '0;
                end else if (!e) begin
                    m_y = '0;
                end else begin
                    m_k++;
                    if (m_k == m_total) begin
                        m_active = 0; m_y = '0; m_done = 1;
                    end else begin
                        m_y = 16'(1) << ((m_start + m_k / (m_dw + 1)) % 16);
                    end
                end
            end else if (!e) begin
                m_y = '0;
            end else if (iv) begin
                m_y = 16'(1) << a;
                if (md) begin
                    m_active = 1; m_k = 0; m_start = int'(a); m_dw = int'(d);
                    m_total = ((int'(l) - int'(a) + 16) % 16 + 1) * (m_dw + 1);
                end
            end
            #1;
            check("rnd.outputs", {y4, y_valid4, busy4, done4}, {m_y, m_y != 0, m_active, m_done});
            check("rnd.onehot", $onehot0(y4), 1);
        end
        en4 = 0; in_valid4 = 0; abort4 = 0;
    endtask

    initial begin
        rst_n = 0;
        en = 0; in_valid = 0; mode = 0; abort = 0; addr = '0; scan_last = '0; dwell = '0;
        en4 = 0; in_valid4 = 0; mode4 = 0; abort4 = 0; addr4 = '0; scan_last4 = '0; dwell4 = '0;

        vecs.push_back(mk(1,0,0,0,0,0,0, 1,8'h00,0,0,0));
        vecs.push_back(mk(1,1,0,5,0,0,0, 1,8'h20,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,8'h01,1,0,0));
        vecs.push_back(mk(1,1,1,6,1,0,0, 1,8'h40,1,1,0));
        vecs.push_back(mk(1,1,0,3,0,0,0, 0,8'h80,1,1,0));
        vecs.push_back(mk(1,1,1,4,4,0,0, 0,8'h01,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h02,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h00,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,8'h00,0,0,0));
        vecs.push_back(mk(1,1,1,2,2,2,0, 1,8'h04,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h04,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h04,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h00,0,0,1));
        vecs.push_back(mk(1,1,0,7,0,0,0, 1,8'h80,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,1, 1,8'h80,1,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,0, 0,8'h00,0,0,0));
        vecs.push_back(mk(1,1,1,7,7,0,0, 1,8'h80,1,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,8'h00,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,8'h00,0,0,0));

        #12;
        check("reset.y", y, 0);
        check("reset.flags", {y_valid, busy, done}, 3'b000);
        check("reset.ready_en0", in_ready, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; in_valid = vecs[i].iv; mode = vecs[i].md;
            addr = vecs[i].a; scan_last = vecs[i].l; dwell = vecs[i].d; abort = vecs[i].ab;
            #1 check($sformatf("vec%0d.ready", i), in_ready, vecs[i].rdy);
            @(posedge clk); #1;
            check($sformatf("vec%0d.y", i), y, vecs[i].ey);
            check($sformatf("vec%0d.flags", i), {y_valid, busy, done},
                  {vecs[i].yv, vecs[i].bz, vecs[i].dn});
        end
        in_valid = 0; abort = 0; en = 1;

        pause_test();
        abort_test();
        reset_test();
        random_test(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dec_seq.md
# dec_seq

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. In direct mode it decodes a single accepted address and holds the one-hot output. In scan mode it walks the one-hot output through a range of addresses, with wrap-around and a programmable dwell per position. It drives row/bank/chip-select style enables where a select must be held for several cycles or swept automatically.

## Interface
Parameters:
- N, 3, address width; the output is 2^N bits wide
- DWELL_W, 4, width of the dwell count

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; low forces outputs inactive and freezes a scan
- in_valid  input  1  command valid
- in_ready  output  1  command ready; combinational, equals en && (state != SCAN)
- mode  input  1  sampled on accept; 0 = direct, 1 = scan
- addr  input  N  direct address, or scan start address
- scan_last  input  N  scan end address, inclusive; sampled on accept
- dwell  input  DWELL_W  number of extra cycles each scan position is held; sampled on accept
- abort  input  1  terminates a scan
- y  output  2^N  registered one-hot output, or all zeros
- y_valid  output  1  registered; high exactly when y is non-zero
- busy  output  1  registered; high while in SCAN
- done  output  1  registered; 1-cycle pulse when a scan completes normally

## Operation
- States: IDLE, DIRECT, SCAN.
- Accept condition: in_valid && in_ready. Outside an accept, in_valid is ignored; there is no queuing.
- Direct accept (mode=0), from IDLE or DIRECT:
  - y <= 1 << addr; y_valid <= 1; next state DIRECT.
  - y is held until the next accept, or until en goes low.
- Scan accept (mode=1), from IDLE or DIRECT:
  - Latch cursor = addr, last = scan_last, dwell_cfg = dwell.
  - Load dwell_cnt = dwell.
  - y <= 1 << addr; busy <= 1; next state SCAN.
- SCAN, each cycle with en=1:
  - If dwell_cnt != 0: decrement dwell_cnt.
  - Else if cursor != last: cursor <= cursor + 1 (mod 2^N, wraps 2^N-1 to 0); dwell_cnt <= dwell_cfg; y follows the new cursor.
  - Else: scan ends. Next state IDLE; y <= 0, y_valid <= 0, busy <= 0, done <= 1 for one cycle.
- Positions visited: ((last - start) mod 2^N) + 1.
  - start == last visits a single position.
  - Each position is held dwell+1 cycles.
- en low in SCAN (pause):
  - Next cycle y=0 and y_valid=0; busy stays 1.
  - cursor and dwell_cnt are frozen.
  - When en returns high, y <= 1 << cursor on the next edge and counting resumes. Paused cycles do not consume dwell.
- en low in DIRECT: next cycle y=0, y_valid=0, state IDLE.
- abort in SCAN (takes priority over en and over completion):
  - Next cycle y=0, y_valid=0, busy=0, state IDLE.
  - done is not pulsed.
  - abort is ignored outside SCAN.
- Reset clears all state asynchronously, whenever asserted (including mid-scan): state=IDLE, y=0, y_valid=0, busy=0, done=0, cursor=0, dwell_cnt=0.

## Timing
- Accept at edge t: y, y_valid and busy are valid from cycle t+1, i.e. 1-cycle latency.
- Scan with no pause: done is high in cycle t+1+count*(dwell+1); y=0 in that same cycle.
- in_ready is high in the done cycle, so a new command can be accepted there; back-to-back scans have exactly 1 zero-output cycle between them.
- y is glitch-free: it is driven from registers only.
- y_valid == (y != 0) at all times.
- At most one bit of y is set at any time.

## Test plan
- N=3, direct accept addr=5 at edge t -> y=0x20, y_valid=1 from t+1; second accept addr=0 -> y=0x01 the next cycle.
- Scan start=6, last=1, dwell=0 -> y=0x40, 0x80, 0x01, 0x02 on consecutive cycles, then y=0 with done=1 for exactly one cycle; in_valid pulses during the scan are ignored and in_ready=0.
- Scan start=2, last=2, dwell=2 -> y=0x04 for 3 cycles, then done; immediately accept a direct command with addr=7 in the done cycle -> y=0x80 on the next cycle.
- Scan start=0, last=3, dwell=1, en low for 4 cycles while at cursor=1 -> y=0 during the pause, busy=1; y=0x02 resumes with its remaining dwell intact; total high-output cycles = 8.
- abort asserted while at cursor=2 -> next cycle y=0, busy=0, no done pulse; rst_n asserted mid-scan -> outputs clear asynchronously, and after release in_ready equals en.
- Randomised N=4, DWELL_W=3 scans with random en/abort -> scoreboard checks the position sequence, per-position hold counts and the one-hot invariant.
